// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//  Instruction memory with a byte-stream program loader in front of it.
//  A frame is LEN_LO, LEN_HI (N = word count), then 4*N data bytes,
//  little-endian per word. The packed words are written to mem[0..N-1].
//  The core reads through a 1-cycle registered port. last_pc marks the final
//  loaded word, and core_run releases the core once a frame has loaded cleanly.
//
//  Optional feature: define IMEM_CHECKSUM_EN to require a trailing byte after
//  the data bytes. That byte must equal the XOR of all data bytes, or the
//  frame is rejected.
//
//  Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   [7:0]  stream byte
//   rx_valid    in   stream byte valid
//   rx_ready    out  loader accepts the byte this cycle (low only in WR / reset)
//   instr_addr  in   [31:0] word address from the core (pc_next)
//   instr_data  out  [31:0] registered instruction word (NOP when unreachable)
//   last_pc     out  [31:0] index of the last loaded word, all-ones if none
//   core_run    out  program loaded, core may execute
//   load_err    out  last frame rejected, sticky until the next frame starts
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int          ADDR_W = 8,
   parameter logic [31:0] NOP    = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_data,
   output logic [31:0] last_pc,
   output logic        core_run,
   output logic        load_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_WR     = 3'd3,
      S_CHK    = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_W;
   localparam logic [31:0] NO_PC_C = 32'hFFFFFFFF;

   state_t        state_r;
   state_t        state_next_s;
   logic          rx_ready_r;
   logic [31:0]   instr_data_r;
   logic [31:0]   last_pc_r;
   logic          core_run_r;
   logic          load_err_r;
   logic [7:0]    len_lo_r;
   logic [15:0]   len_r;
   logic [15:0]   word_cnt_r;
   logic [1:0]    byte_cnt_r;
   logic [31:0]   word_r;
   logic [31:0]   mem_r [2**ADDR_W];

   logic          accept_s;
   logic [15:0]   len_s;
   logic          len_bad_s;
   logic          wr_last_s;
   logic          frame_start_s;
   logic          len_take_s;
   logic          data_take_s;
   logic          mem_we_s;
   logic          set_done_s;
   logic          set_err_s;

`ifdef IMEM_CHECKSUM_EN
   logic [7:0]    csum_r;
   logic          csum_ok_s;

   // Running XOR checksum over the data bytes
   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   assign csum_ok_s = (rx_data == csum_r);
`endif

   assign accept_s  = rx_valid & rx_ready_r;
   assign len_s     = {rx_data, len_lo_r};
   // N must be 1..2**ADDR_W; the compare is done one bit wider so depth 2**16 still fits
   assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > DEPTH_C);
   assign wr_last_s = ((word_cnt_r + 16'd1) == len_r);

   assign rx_ready   = rx_ready_r;
   assign instr_data = instr_data_r;
   assign last_pc    = last_pc_r;
   assign core_run   = core_run_r;
   assign load_err   = load_err_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         // DONE and ERR treat the next byte as LEN_LO of a new frame
         S_IDLE, S_DONE, S_ERR: begin
            if (accept_s) state_next_s = S_LEN_HI;
            else          state_next_s = state_r;
         end
         S_LEN_HI: begin
            if (accept_s) state_next_s = len_bad_s ? S_ERR : S_DATA;
            else          state_next_s = state_r;
         end
         S_DATA: begin
            if (accept_s && (byte_cnt_r == 2'd3)) state_next_s = S_WR;
            else                                  state_next_s = state_r;
         end
         S_WR: begin
`ifdef IMEM_CHECKSUM_EN
            if (wr_last_s) state_next_s = S_CHK;
`else
            if (wr_last_s) state_next_s = S_DONE;
`endif
            else           state_next_s = S_DATA;
         end
         S_CHK: begin
`ifdef IMEM_CHECKSUM_EN
            if (accept_s) state_next_s = csum_ok_s ? S_DONE : S_ERR;
            else          state_next_s = state_r;
`else
            state_next_s = S_ERR;
`endif
         end
         default: state_next_s = S_IDLE;
      endcase
   end

   // Control decode per state
   always_comb begin
      frame_start_s = 1'b0;
      len_take_s    = 1'b0;
      data_take_s   = 1'b0;
      mem_we_s      = 1'b0;
      set_done_s    = 1'b0;
      set_err_s     = 1'b0;
      case (state_r)
         S_IDLE, S_DONE, S_ERR: frame_start_s = accept_s;
         S_LEN_HI: begin
            len_take_s = accept_s;
            set_err_s  = accept_s & len_bad_s;
         end
         S_DATA: data_take_s = accept_s;
         S_WR: begin
            mem_we_s = 1'b1;
`ifndef IMEM_CHECKSUM_EN
            set_done_s = wr_last_s;
`endif
         end
         S_CHK: begin
`ifdef IMEM_CHECKSUM_EN
            set_done_s = accept_s & csum_ok_s;
            set_err_s  = accept_s & ~csum_ok_s;
`else
            set_err_s  = 1'b1;
`endif
         end
         default: frame_start_s = 1'b0;
      endcase
   end

   // Loader datapath and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ready_r <= 1'b0;
         last_pc_r  <= NO_PC_C;
         core_run_r <= 1'b0;
         load_err_r <= 1'b0;
         len_lo_r   <= 8'd0;
         len_r      <= 16'd0;
         word_cnt_r <= 16'd0;
         byte_cnt_r <= 2'd0;
         word_r     <= 32'd0;
`ifdef IMEM_CHECKSUM_EN
         csum_r     <= 8'd0;
`endif
      end else begin
         // Registered ready: low only for the single WR cycle
         rx_ready_r <= (state_next_s != S_WR);
         if (frame_start_s) begin
            len_lo_r   <= rx_data;
            load_err_r <= 1'b0;
            core_run_r <= 1'b0;
            last_pc_r  <= NO_PC_C;
         end else if (set_err_s) begin
            load_err_r <= 1'b1;
            core_run_r <= 1'b0;
            last_pc_r  <= NO_PC_C;
         end else if (set_done_s) begin
            core_run_r <= 1'b1;
            last_pc_r  <= {16'd0, len_r} - 32'd1;
         end
         if (len_take_s) begin
            len_r      <= len_s;
            word_cnt_r <= 16'd0;
            byte_cnt_r <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
         end
         if (data_take_s) begin
            // Shift right so the first byte ends in [7:0] after four bytes
            word_r     <= {rx_data, word_r[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            csum_r     <= csum_next(csum_r, rx_data);
`endif
         end
         if (mem_we_s) begin
            word_cnt_r <= word_cnt_r + 16'd1;
         end
      end
   end

   // Memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[word_cnt_r[ADDR_W-1:0]] <= word_r;
      end
   end

   // Registered read port; full 32-bit range check, gated by core_run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_data_r <= NOP;
      end else begin
         if (core_run_r && (instr_addr < {16'd0, len_r})) begin
            instr_data_r <= mem_r[instr_addr[ADDR_W-1:0]];
         end else begin
            instr_data_r <= NOP;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//  Directed self-checking bench for imem_loader. Bytes are driven on the
//  falling edge and outputs are sampled on the falling edge. Define
//  IMEM_CHECKSUM_EN for both this file and the RTL to exercise the checksum
//  trailer.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam logic [31:0] NOP_C = 32'h00000013;
   localparam logic [31:0] NO_PC = 32'hFFFFFFFF;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] instr_addr;
   logic [31:0] instr_data;
   logic [31:0] last_pc;
   logic        core_run;
   logic        load_err;

   int          checks;
   int          errors;
   logic [7:0]  csum_m;

   imem_loader #(.ADDR_W(8), .NOP(NOP_C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .last_pc    (last_pc),
      .core_run   (core_run),
      .load_err   (load_err)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Present one byte from a falling edge; returns after the edge that takes it
   task automatic send_byte(input logic [7:0] b, output int waits);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_val("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      waits = n;
      @(negedge clk);
   endtask

   task automatic send_len(input logic [15:0] n);
      int w;
      csum_m = 8'h00;
      send_byte(n[7:0], w);
      send_byte(n[15:8], w);
   endtask

   task automatic send_word(input logic [31:0] wd);
      int w;
      for (int i = 0; i < 4; i++) begin
         send_byte(wd[8*i +: 8], w);
         csum_m = csum_m ^ wd[8*i +: 8];
      end
   endtask

   // Closes a frame (checksum trailer when enabled) and lets WR/DONE settle
   task automatic end_frame();
      int w;
`ifdef IMEM_CHECKSUM_EN
      send_byte(csum_m, w);
`endif
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      instr_addr = addr;
      @(negedge clk);
      check_val(tag, instr_data, exp);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_ready"},  {31'd0, rx_ready}, 32'd0);
      check_val({tag, "_data"},   instr_data, NOP_C);
      check_val({tag, "_lastpc"}, last_pc, NO_PC);
      check_val({tag, "_run"},    {31'd0, core_run}, 32'd0);
      check_val({tag, "_err"},    {31'd0, load_err}, 32'd0);
   endtask

   logic [7:0] frame1 [10];
   int         wt;

   initial begin
      checks     = 0;
      errors     = 0;
      csum_m     = 8'h00;
      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      instr_addr = 32'd0;
      frame1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};

      // Reset values
      repeat (2) @(negedge clk);
      check_idle_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_val("ready_after_rst", {31'd0, rx_ready}, 32'd1);

      // Test 1 + 3: 2-word frame with rx_valid held high; one stall after each 4th byte
      for (int i = 0; i < 10; i++) begin
         send_byte(frame1[i], wt);
         if (i == 1) csum_m = 8'h00;
         if (i >= 2) csum_m = csum_m ^ frame1[i];
         check_val($sformatf("stall_b%0d", i), wt, (i == 6) ? 32'd1 : 32'd0);
      end
      check_val("wr_ready_low", {31'd0, rx_ready}, 32'd0);
      end_frame();
      check_val("t1_lastpc", last_pc, 32'd1);
      check_val("t1_run", {31'd0, core_run}, 32'd1);
      check_val("t1_err", {31'd0, load_err}, 32'd0);
      check_val("t1_ready", {31'd0, rx_ready}, 32'd1);

      // Test 2: consecutive reads, out-of-range and full-width address compare
      read_check("rd0", 32'd0, 32'h00100013);
      read_check("rd1", 32'd1, 32'h002000B3);
      read_check("rd2", 32'd2, NOP_C);
      read_check("rd_ffff", 32'hFFFFFFFF, NOP_C);
      read_check("rd_hi", 32'h00000101, NOP_C);
      read_check("rd0_again", 32'd0, 32'h00100013);

      // Test 4: zero-length frame
      instr_addr = 32'd0;
      send_len(16'h0000);
      rx_valid = 1'b0;
      @(negedge clk);
      check_val("len0_err", {31'd0, load_err}, 32'd1);
      check_val("len0_lastpc", last_pc, NO_PC);
      check_val("len0_run", {31'd0, core_run}, 32'd0);
      check_val("len0_data", instr_data, NOP_C);
      // Too long: 257 words
      send_len(16'h0101);
      rx_valid = 1'b0;
      @(negedge clk);
      check_val("len257_err", {31'd0, load_err}, 32'd1);
      check_val("len257_lastpc", last_pc, NO_PC);
      check_val("len257_run", {31'd0, core_run}, 32'd0);
      // Good frame clears the error
      send_len(16'h0001);
      check_val("new_frame_err_clr", {31'd0, load_err}, 32'd0);
      send_word(32'h12345678);
      end_frame();
      check_val("t4_err", {31'd0, load_err}, 32'd0);
      check_val("t4_run", {31'd0, core_run}, 32'd1);
      check_val("t4_lastpc", last_pc, 32'd0);
      read_check("t4_rd0", 32'd0, 32'h12345678);
      read_check("t4_rd1", 32'd1, NOP_C);

      // Largest legal frame: 256 words
      send_len(16'h0100);
      for (int i = 0; i < 256; i++) begin
         send_word({8'hA5, i[7:0], 8'h5A, ~i[7:0]});
      end
      end_frame();
      check_val("full_lastpc", last_pc, 32'd255);
      check_val("full_run", {31'd0, core_run}, 32'd1);
      read_check("full_rd0", 32'd0, 32'hA5005AFF);
      read_check("full_rd255", 32'd255, 32'hA5FF5A00);
      read_check("full_rd256", 32'd256, NOP_C);

      // Test 5: reset after 5 data bytes of a 2-word frame
      send_len(16'h0002);
      send_word(32'hDDCCBBAA);
      send_byte(8'hEE, wt);
      rx_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_len(16'h0002);
      send_word(32'h44332211);
      send_word(32'h88776655);
      end_frame();
      check_val("t5_lastpc", last_pc, 32'd1);
      check_val("t5_run", {31'd0, core_run}, 32'd1);
      read_check("t5_rd0", 32'd0, 32'h44332211);
      read_check("t5_rd1", 32'd1, 32'h88776655);

`ifdef IMEM_CHECKSUM_EN
      // Test 6: checksum trailer
      send_len(16'h0001);
      send_word(32'h00100013);
      send_byte(8'h03, wt);
      rx_valid = 1'b0;
      @(negedge clk);
      check_val("ck_ok_run", {31'd0, core_run}, 32'd1);
      check_val("ck_ok_err", {31'd0, load_err}, 32'd0);
      check_val("ck_ok_lastpc", last_pc, 32'd0);
      send_len(16'h0001);
      send_word(32'h00100013);
      send_byte(8'h04, wt);
      rx_valid = 1'b0;
      @(negedge clk);
      check_val("ck_bad_err", {31'd0, load_err}, 32'd1);
      check_val("ck_bad_run", {31'd0, core_run}, 32'd0);
      check_val("ck_bad_lastpc", last_pc, NO_PC);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
